// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the sync_fifo_v2 family
//
// Purpose : read-mode selectors for SHOWAHEAD and a constant clog2 helper
//           used to check that the pointer width matches the depth.
// Ports   : none (package)
package fifo_pkg;

    // Read-mode selectors for the SHOWAHEAD parameter
    localparam int SHOWAHEAD_REG  = 0;  // registered read, one cycle after rden
    localparam int SHOWAHEAD_FWFT = 1;  // first-word-fall-through

    // Smallest r with 2**r >= value; evaluated at elaboration only
    function automatic int fifo_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// rtl/fifo_dpram.sv - simple dual-port storage array for sync_fifo_v2
//
// Purpose : DEPTH x WIDTH array, one synchronous write port and one
//           asynchronous read port on the same clock. Contents are never
//           reset; the FIFO control logic decides which entries are valid.
// Ports   : clk      in  1      write clock
//           wr_en    in  1      write strobe
//           wr_addr  in  PTR    write address
//           wr_data  in  WIDTH  write data
//           rd_addr  in  PTR    read address
//           rd_data  out WIDTH  mem[rd_addr]
module fifo_dpram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR   = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR-1:0]   wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR-1:0]   rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A word written on edge N is only seen after edge N, so there is no
    // same-cycle write-to-read bypass.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_v2.sv
// rtl/sync_fifo_v2.sv - single-clock FIFO with status flags and sticky errors
//
// Purpose : pointer, occupancy and flag control around one fifo_dpram.
//           SHOWAHEAD=0 gives a registered read, SHOWAHEAD=1 gives
//           first-word-fall-through with rden acting as pop-acknowledge.
// Ports   : clk           in  1      sole clock, rising edge
//           reset         in  1      synchronous active-high reset
//           clear         in  1      synchronous flush of contents
//           wren, datain  in  1/W    write request and data
//           rden          in  1      read request / pop-acknowledge
//           dataout       out WIDTH  read data
//           full, empty, almost_full, almost_empty  out  status flags
//           usedw         out PTR+1  entries stored, 0..DEPTH
//           overflow, underflow      out  sticky error flags
module sync_fifo_v2
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR       = 4,
    parameter int SHOWAHEAD = SHOWAHEAD_REG,
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wren,
    input  logic [WIDTH-1:0] datain,
    input  logic             rden,
    output logic [WIDTH-1:0] dataout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [PTR:0]     usedw,
    output logic             overflow,
    output logic             underflow
);

    // Parameter sanity checks, reported at elaboration
    if (DEPTH != (1 << PTR)) begin : g_chk_depth_pow2
        $error("sync_fifo_v2: DEPTH must equal 2**PTR");
    end
    if (PTR != fifo_clog2(DEPTH)) begin : g_chk_ptr_clog2
        $error("sync_fifo_v2: PTR must equal clog2(DEPTH)");
    end
    if (DEPTH < 4) begin : g_chk_depth_min
        $error("sync_fifo_v2: DEPTH must be at least 4");
    end
    if (AE_LEVEL >= AF_LEVEL) begin : g_chk_levels
        $error("sync_fifo_v2: AE_LEVEL must be below AF_LEVEL");
    end
    if (SHOWAHEAD != SHOWAHEAD_REG && SHOWAHEAD != SHOWAHEAD_FWFT) begin : g_chk_mode
        $error("sync_fifo_v2: SHOWAHEAD must be 0 or 1");
    end

    localparam logic [PTR:0]   DEPTH_C = (PTR+1)'(DEPTH);
    localparam logic [PTR:0]   AF_C    = (PTR+1)'(AF_LEVEL);
    localparam logic [PTR:0]   AE_C    = (PTR+1)'(AE_LEVEL);
    localparam logic [PTR-1:0] PTR_ONE = PTR'(1);

    logic [PTR-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR:0]     usedw_q, usedw_d;
    logic             full_q, empty_q, af_q, ae_q;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] dataout_q, dataout_d;

    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] mem_rd;

    // clear wins over both requests; full/empty gating also resolves the
    // simultaneous-request corner cases (only the read at full, only the
    // write at empty).
    assign wr_acc = wren & ~full_q  & ~clear;
    assign rd_acc = rden & ~empty_q & ~clear;

    fifo_dpram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR   (PTR)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (datain),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        usedw_d   = usedw_q;
        dataout_d = dataout_q;
        // Error flags are sticky and ignore requests made during a clear
        ovf_d     = ovf_q | (wren & full_q  & ~clear);
        udf_d     = udf_q | (rden & empty_q & ~clear);

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usedw_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                dataout_d = mem_rd;
            end
            usedw_d = usedw_q + (PTR+1)'(wr_acc) - (PTR+1)'(rd_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            usedw_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            dataout_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            usedw_q   <= usedw_d;
            // Flags come from the next count so they line up with usedw
            full_q    <= (usedw_d == DEPTH_C);
            empty_q   <= (usedw_d == '0);
            af_q      <= (usedw_d >= AF_C);
            ae_q      <= (usedw_d <= AE_C);
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            dataout_q <= dataout_d;
        end
    end

    // In show-ahead mode the head word is driven straight from storage while
    // the FIFO holds data; when empty the last popped word is held instead.
    if (SHOWAHEAD == SHOWAHEAD_FWFT) begin : g_fwft
        assign dataout = empty_q ? dataout_q : mem_rd;
    end else begin : g_reg
        assign dataout = dataout_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign usedw        = usedw_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb/tb_sync_fifo_v2.sv - directed self-checking bench for sync_fifo_v2
module tb_sync_fifo_v2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    // Registered-read instance
    logic       clear = 1'b0, wren = 1'b0, rden = 1'b0;
    logic [7:0] datain = 8'h00;
    logic [7:0] dataout;
    logic       full, empty, af, ae, ovf, udf;
    logic [4:0] usedw;

    // Show-ahead instance
    logic       clear1 = 1'b0, wren1 = 1'b0, rden1 = 1'b0;
    logic [7:0] datain1 = 8'h00;
    logic [7:0] dataout1;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0] usedw1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_v2 #(.WIDTH(8), .DEPTH(16), .PTR(4), .SHOWAHEAD(0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .wren(wren), .datain(datain),
        .rden(rden), .dataout(dataout), .full(full), .empty(empty),
        .almost_full(af), .almost_empty(ae), .usedw(usedw),
        .overflow(ovf), .underflow(udf)
    );

    sync_fifo_v2 #(.WIDTH(8), .DEPTH(16), .PTR(4), .SHOWAHEAD(1)) dut_sa (
        .clk(clk), .reset(reset), .clear(clear1), .wren(wren1), .datain(datain1),
        .rden(rden1), .dataout(dataout1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .usedw(usedw1),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_usedw"}, 32'(usedw), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"},  32'(full),  32'd0);
        chk({tag, "_ae"},    32'(ae),    32'd1);
        chk({tag, "_af"},    32'(af),    32'd0);
        chk({tag, "_ovf"},   32'(ovf),   32'd0);
        chk({tag, "_udf"},   32'(udf),   32'd0);
        chk({tag, "_dout"},  32'(dataout), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        tick();
        tick();
        reset = 1'b0;
        chk_reset_state("rst");
        chk("sa_rst_empty", 32'(empty1), 32'd1);
        chk("sa_rst_dout",  32'(dataout1), 32'd0);

        // ---------------- fill 0x01..0x10 ----------------
        wren = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            datain = 8'(i);
            tick();
            chk("fill_usedw", 32'(usedw), 32'(i));
            if (i == 2)  chk("fill_ae_at2",  32'(ae), 32'd1);
            if (i == 3)  chk("fill_ae_at3",  32'(ae), 32'd0);
            if (i == 13) chk("fill_af_at13", 32'(af), 32'd0);
            if (i == 14) chk("fill_af_at14", 32'(af), 32'd1);
        end
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_empty", 32'(empty), 32'd0);
        chk("fill_ovf0",  32'(ovf),   32'd0);

        // 17th write is rejected
        datain = 8'hAA;
        tick();
        wren = 1'b0;
        chk("ovf_set",   32'(ovf),   32'd1);
        chk("ovf_usedw", 32'(usedw), 32'd16);
        chk("ovf_full",  32'(full),  32'd1);

        // ---------------- drain ----------------
        rden = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("drain_dout",  32'(dataout), 32'(i));
            chk("drain_usedw", 32'(usedw), 32'(16 - i));
            if (i == 3)  chk("drain_af_at13", 32'(af), 32'd0);
            if (i == 2)  chk("drain_af_at14", 32'(af), 32'd1);
            if (i == 14) chk("drain_ae_at2",  32'(ae), 32'd1);
            if (i == 13) chk("drain_ae_at3",  32'(ae), 32'd0);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        tick();
        rden = 1'b0;
        chk("udf_set",   32'(udf),     32'd1);
        chk("udf_hold",  32'(dataout), 32'h10);
        chk("udf_usedw", 32'(usedw),   32'd0);
        chk("ovf_sticky", 32'(ovf),    32'd1);

        // ---------------- wren & rden at empty ----------------
        do_reset();
        chk("rst2_udf", 32'(udf), 32'd0);
        wren = 1'b1; rden = 1'b1; datain = 8'h33;
        tick();
        wren = 1'b0; rden = 1'b0;
        chk("be_usedw", 32'(usedw),   32'd1);
        chk("be_udf",   32'(udf),     32'd1);
        chk("be_dout",  32'(dataout), 32'd0);
        chk("be_empty", 32'(empty),   32'd0);
        rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("be_read",  32'(dataout), 32'h33);
        chk("be_empty2", 32'(empty),  32'd1);

        // ---------------- wren & rden at full ----------------
        wren = 1'b1;
        for (int i = 0; i < 16; i++) begin
            datain = 8'(8'h40 + i);
            tick();
        end
        chk("bf_full", 32'(full), 32'd1);
        rden = 1'b1; datain = 8'hEE;
        tick();
        wren = 1'b0; rden = 1'b0;
        chk("bf_usedw", 32'(usedw),   32'd15);
        chk("bf_full2", 32'(full),    32'd0);
        chk("bf_dout",  32'(dataout), 32'h40);
        chk("bf_ovf",   32'(ovf),     32'd1);

        // ---------------- wrap, usedw held at 3 ----------------
        do_reset();
        wren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            datain = 8'(8'h80 + i);
            tick();
        end
        rden = 1'b1;
        for (int i = 0; i < 40; i++) begin
            datain = 8'(8'h83 + i);
            tick();
            chk("wrap_dout",  32'(dataout), 32'(8'h80 + i));
            chk("wrap_usedw", 32'(usedw), 32'd3);
        end
        wren = 1'b0; rden = 1'b0;

        // ---------------- clear ----------------
        do_reset();
        rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("clr_pre_udf", 32'(udf), 32'd1);
        wren = 1'b1;
        for (int i = 0; i < 8; i++) begin
            datain = 8'(8'h60 + i);
            tick();
        end
        wren = 1'b0; rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("clr_pre_usedw", 32'(usedw),   32'd7);
        chk("clr_pre_dout",  32'(dataout), 32'h60);
        clear = 1'b1; wren = 1'b1; datain = 8'hCC;
        tick();
        clear = 1'b0; wren = 1'b0;
        chk("clr_usedw", 32'(usedw),   32'd0);
        chk("clr_empty", 32'(empty),   32'd1);
        chk("clr_udf",   32'(udf),     32'd1);
        chk("clr_ovf",   32'(ovf),     32'd0);
        chk("clr_dout",  32'(dataout), 32'h60);
        wren = 1'b1; datain = 8'h77;
        tick();
        wren = 1'b0; rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("clr_first", 32'(dataout), 32'h77);

        // ---------------- reset mid-stream ----------------
        wren = 1'b1;
        for (int i = 0; i < 9; i++) begin
            datain = 8'(8'h90 + i);
            tick();
        end
        wren = 1'b0;
        chk("mid_usedw", 32'(usedw), 32'd9);
        do_reset();
        chk_reset_state("mid_rst");
        wren = 1'b1; datain = 8'h99;
        tick();
        wren = 1'b0; rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("mid_first", 32'(dataout), 32'h99);

        // ---------------- show-ahead instance ----------------
        do_reset();
        wren1 = 1'b1; datain1 = 8'h5A;
        chk("sa_pre_empty", 32'(empty1), 32'd1);
        tick();
        wren1 = 1'b0;
        chk("sa_empty", 32'(empty1),   32'd0);
        chk("sa_dout",  32'(dataout1), 32'h5A);
        chk("sa_usedw", 32'(usedw1),   32'd1);
        rden1 = 1'b1;
        tick();
        rden1 = 1'b0;
        chk("sa_pop_empty", 32'(empty1), 32'd1);
        wren1 = 1'b1; datain1 = 8'h11;
        tick();
        datain1 = 8'h22;
        tick();
        wren1 = 1'b0;
        chk("sa_head1", 32'(dataout1), 32'h11);
        rden1 = 1'b1;
        tick();
        rden1 = 1'b0;
        chk("sa_head2", 32'(dataout1), 32'h22);
        chk("sa_usedw2", 32'(usedw1),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
